// File: rtl/pc_redirect_ctrl.sv
// Execute-stage branch/jump redirect controller: drives fetch redirects, IF/ID flushes and wrong-path squash.
// Optional statistics counters are built only when BR_STATS_EN is defined.
module pc_redirect_ctrl #(
  parameter int XLEN          = 32,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic            ex_br_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            stall_in,
  input  logic            if_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if,
  output logic            flush_id,
  output logic            squash_ex,
  output logic            misalign_err,
  output logic            busy,
  output logic [15:0]     redirect_cnt,
  output logic [15:0]     squash_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SQUASH   = 2'd2
  } state_e;

  localparam int          SQ_LOAD_I = (SQUASH_CYCLES > 0) ? (SQUASH_CYCLES - 1) : 0;
  localparam logic [3:0]  SQ_LOAD   = 4'(SQ_LOAD_I);

  // Only conditional branches, JALR and JAL may redirect fetch.
  function automatic logic is_ctrl_flow(input logic [6:0] op);
    case (op)
      7'b1100011,
      7'b1100111,
      7'b1101111: is_ctrl_flow = 1'b1;
      default:    is_ctrl_flow = 1'b0;
    endcase
  endfunction

  state_e            state_r, state_s;
  logic [3:0]        sq_cnt_r, sq_cnt_s;
  logic [XLEN-1:0]   redirect_pc_r, redirect_pc_s;
  logic              flush_r, flush_s;
  logic              misalign_r, misalign_s;
  logic              redirect_valid_r;
  logic              squash_r;
  logic              busy_r;
  logic              trigger_s;
  logic              aligned_s;

  assign trigger_s = ex_valid & ex_br_taken & ~stall_in & is_ctrl_flow(ex_opcode);
  assign aligned_s = (ex_target[1:0] == 2'b00);

  // Next-state, capture and pulse decode for the redirect FSM.
  always_comb begin
    state_s       = state_r;
    sq_cnt_s      = sq_cnt_r;
    redirect_pc_s = redirect_pc_r;
    flush_s       = 1'b0;
    misalign_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trigger_s) begin
          if (aligned_s) begin
            state_s       = ST_REDIRECT;
            redirect_pc_s = ex_target;
            flush_s       = 1'b1;
          end else begin
            misalign_s    = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        // Wrong-path triggers are ignored here; only the fetch handshake moves us on.
        if (if_ready) begin
          if (SQUASH_CYCLES > 0) begin
            state_s  = ST_SQUASH;
            sq_cnt_s = SQ_LOAD;
          end else begin
            state_s  = ST_IDLE;
            sq_cnt_s = 4'd0;
          end
        end else begin
          state_s = ST_REDIRECT;
        end
      end
      ST_SQUASH: begin
        if (sq_cnt_r == 4'd0) begin
          state_s = ST_IDLE;
        end else begin
          state_s  = ST_SQUASH;
          sq_cnt_s = sq_cnt_r - 4'd1;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        sq_cnt_s = 4'd0;
      end
    endcase
  end

  // State register and registered outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      sq_cnt_r         <= 4'd0;
      redirect_pc_r    <= '0;
      flush_r          <= 1'b0;
      misalign_r       <= 1'b0;
      redirect_valid_r <= 1'b0;
      squash_r         <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      state_r          <= state_s;
      sq_cnt_r         <= sq_cnt_s;
      redirect_pc_r    <= redirect_pc_s;
      flush_r          <= flush_s;
      misalign_r       <= misalign_s;
      redirect_valid_r <= (state_s == ST_REDIRECT);
      squash_r         <= (state_s == ST_SQUASH);
      busy_r           <= (state_s != ST_IDLE);
    end
  end

  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign flush_if       = flush_r;
  assign flush_id       = flush_r;
  assign squash_ex      = squash_r;
  assign misalign_err   = misalign_r;
  assign busy           = busy_r;

`ifdef BR_STATS_EN
  logic [15:0] redirect_cnt_r;
  logic [15:0] squash_cnt_r;
  logic        redirect_hs_s;

  assign redirect_hs_s = (state_r == ST_REDIRECT) & if_ready;

  // Saturating statistics: accepted redirects and squashed execute cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_cnt_r <= 16'd0;
      squash_cnt_r   <= 16'd0;
    end else begin
      if (redirect_hs_s && (redirect_cnt_r != 16'hFFFF)) begin
        redirect_cnt_r <= redirect_cnt_r + 16'd1;
      end else begin
        redirect_cnt_r <= redirect_cnt_r;
      end
      if (squash_r && (squash_cnt_r != 16'hFFFF)) begin
        squash_cnt_r <= squash_cnt_r + 16'd1;
      end else begin
        squash_cnt_r <= squash_cnt_r;
      end
    end
  end

  assign redirect_cnt = redirect_cnt_r;
  assign squash_cnt   = squash_cnt_r;
`else
  assign redirect_cnt = 16'd0;
  assign squash_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed, table-driven bench for pc_redirect_ctrl (XLEN=32, SQUASH_CYCLES=2), plus a hand-written
// long-hold redirect sequence.
module tb_pc_redirect_ctrl;

  localparam logic [6:0] OP_NOP  = 7'b0000000;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic        ex_br_taken;
  logic [31:0] ex_target;
  logic        stall_in;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  logic        squash_ex;
  logic        misalign_err;
  logic        busy;
  logic [15:0] redirect_cnt;
  logic [15:0] squash_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.XLEN(32), .SQUASH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_br_taken(ex_br_taken), .ex_target(ex_target), .stall_in(stall_in),
    .if_ready(if_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id), .squash_ex(squash_ex),
    .misalign_err(misalign_err), .busy(busy), .redirect_cnt(redirect_cnt),
    .squash_cnt(squash_cnt)
  );

  // Inputs applied before an edge, and the outputs expected just after that edge.
  typedef struct {
    logic        rst_n;
    logic        ex_valid;
    logic [6:0]  op;
    logic        taken;
    logic [31:0] target;
    logic        stall;
    logic        rdy;
    logic        rv;
    logic [31:0] pc;
    logic        flush;
    logic        sq;
    logic        mis;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [6:0] op, input logic tk,
                              input logic [31:0] tgt, input logic st, input logic rdy,
                              input logic rv, input logic [31:0] pc, input logic fl,
                              input logic sq, input logic mis, input logic bsy);
    vec_t t;
    t.rst_n = r;  t.ex_valid = v; t.op = op;  t.taken = tk; t.target = tgt;
    t.stall = st; t.rdy = rdy;    t.rv = rv;  t.pc = pc;    t.flush = fl;
    t.sq = sq;    t.mis = mis;    t.busy = bsy;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [6:0] op, input logic tk,
                       input logic [31:0] tgt, input logic st, input logic rdy);
    rst_n = r; ex_valid = v; ex_opcode = op; ex_br_taken = tk;
    ex_target = tgt; stall_in = st; if_ready = rdy;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] rcnt0;
    logic [15:0] scnt0;
    int          sq_seen;
    bit          done;

    //        rst v  op       tk target        st rdy | rv pc            fl sq mis busy
    vecs.push_back(mk(0, 0, OP_NOP,  0, 32'h0,   0, 0,  0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_BEQ,  1, 32'h100, 0, 1,  0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, OP_NOP,  0, 32'h0,   0, 1,  0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_BEQ,  1, 32'h100, 0, 0,  1, 32'h100, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, OP_NOP,  0, 32'h0,   0, 1,  0, 32'h100, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, OP_NOP,  0, 32'h0,   0, 0,  0, 32'h100, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, OP_NOP,  0, 32'h0,   0, 0,  0, 32'h100, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_JALR, 1, 32'h102, 0, 0,  0, 32'h100, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, OP_NOP,  0, 32'h0,   0, 0,  0, 32'h100, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_JAL,  1, 32'h201, 0, 0,  0, 32'h100, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, OP_NOP,  0, 32'h0,   0, 0,  0, 32'h100, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_BEQ,  1, 32'h300, 1, 0,  0, 32'h100, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_ALU,  1, 32'h300, 0, 0,  0, 32'h100, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_BEQ,  0, 32'h300, 0, 0,  0, 32'h100, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, OP_BEQ,  1, 32'h300, 0, 0,  0, 32'h100, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_JAL,  1, 32'h400, 0, 0,  1, 32'h400, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, OP_NOP,  0, 32'h0,   0, 0,  1, 32'h400, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, OP_JAL,  1, 32'h404, 0, 1,  0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, OP_NOP,  0, 32'h0,   0, 0,  0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_JAL,  1, 32'h500, 0, 0,  1, 32'h500, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, OP_BEQ,  1, 32'h600, 0, 1,  0, 32'h500, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, OP_BEQ,  1, 32'h700, 0, 0,  0, 32'h500, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, OP_BEQ,  1, 32'h800, 0, 1,  0, 32'h500, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_JALR, 1, 32'h900, 0, 1,  1, 32'h900, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, OP_NOP,  0, 32'h0,   0, 1,  0, 32'h900, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, OP_NOP,  0, 32'h0,   0, 0,  0, 32'h900, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, OP_NOP,  0, 32'h0,   0, 0,  0, 32'h900, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].ex_valid, vecs[i].op, vecs[i].taken,
            vecs[i].target, vecs[i].stall, vecs[i].rdy);
      step();
      check($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].rv));
      check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].pc);
      check($sformatf("v%0d flush_if", i), 32'(flush_if), 32'(vecs[i].flush));
      check($sformatf("v%0d flush_id", i), 32'(flush_id), 32'(vecs[i].flush));
      check($sformatf("v%0d squash_ex", i), 32'(squash_ex), 32'(vecs[i].sq));
      check($sformatf("v%0d misalign_err", i), 32'(misalign_err), 32'(vecs[i].mis));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
`ifndef BR_STATS_EN
      check($sformatf("v%0d redirect_cnt", i), 32'(redirect_cnt), 32'd0);
      check($sformatf("v%0d squash_cnt", i), 32'(squash_cnt), 32'd0);
`endif
    end

    // JAL to 0x200 held for five cycles by fetch back-pressure.
    rcnt0 = redirect_cnt;
    scnt0 = squash_cnt;
    drive(1'b1, 1'b1, OP_JAL, 1'b1, 32'h200, 1'b0, 1'b0);
    step();
    check("hold first rv", 32'(redirect_valid), 32'd1);
    check("hold first flush", 32'(flush_if & flush_id), 32'd1);
    check("hold first pc", redirect_pc, 32'h200);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, OP_BEQ, 1'b1, 32'h300 + 32'(k) * 32'h10, 1'b0, 1'b0);
      step();
      check($sformatf("hold%0d rv", k), 32'(redirect_valid), 32'd1);
      check($sformatf("hold%0d pc", k), redirect_pc, 32'h200);
      check($sformatf("hold%0d flush", k), 32'(flush_if | flush_id), 32'd0);
      check($sformatf("hold%0d squash", k), 32'(squash_ex), 32'd0);
    end
    drive(1'b1, 1'b0, OP_NOP, 1'b0, 32'h0, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, OP_NOP, 1'b0, 32'h0, 1'b0, 1'b0);
    sq_seen = 0;
    done    = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      if (squash_ex) sq_seen++;
      if (!busy) done = 1'b1;
      else step();
    end
    check("hold return to idle", 32'(done), 32'd1);
    check("hold squash cycles", 32'(sq_seen), 32'd2);
    check("hold rv after", 32'(redirect_valid), 32'd0);
`ifdef BR_STATS_EN
    check("stats redirect delta", 32'(redirect_cnt - rcnt0), 32'd1);
    check("stats squash delta", 32'(squash_cnt - scnt0), 32'd2);
`else
    check("stats redirect zero", 32'(redirect_cnt | rcnt0), 32'd0);
    check("stats squash zero", 32'(squash_cnt | scnt0), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter: XLEN, 32, address/data width.
REQ-002 Parameter: SQUASH_CYCLES, 2, wrong-path squash cycles after a redirect is accepted (legal range 0..15).
REQ-003 Port: clk  in  1  sole clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous and active-low.
REQ-005 Port: ex_valid  in  1  execute-stage instruction valid.
REQ-006 Port: ex_opcode  in  7  execute-stage opcode.
REQ-007 Port: ex_br_taken  in  1  resolved branch/jump taken flag from branch-condition logic.
REQ-008 Port: ex_target  in  XLEN  resolved target PC.
REQ-009 Port: stall_in  in  1  pipeline stall from hazard unit.
REQ-010 Port: if_ready  in  1  fetch accepts redirect this cycle.
REQ-011 Port: redirect_valid  out  1  redirect request to fetch.
REQ-012 Port: redirect_pc  out  XLEN  redirect target, stable while redirect_valid.
REQ-013 Port: flush_if, flush_id  out  1 each  one-cycle flush pulses to IF and ID registers.
REQ-014 Port: squash_ex  out  1  marks execute-stage instruction as wrong-path.
REQ-015 Port: misalign_err  out  1  one-cycle pulse, taken target not 4-byte aligned.
REQ-016 Port: busy  out  1  high whenever state is not IDLE.
REQ-017 Port: redirect_cnt, squash_cnt  out  16 each  statistics counters (see Configuration).

Function
REQ-018 States: IDLE, REDIRECT, SQUASH; encoded registered FSM.
REQ-019 Trigger = ex_valid & ex_br_taken & !stall_in & opcode in {1100011, 1100111, 1101111}; other opcodes never trigger.
REQ-020 IDLE + trigger + ex_target[1:0]==0: capture ex_target into redirect_pc, next state REDIRECT.
REQ-021 IDLE + trigger + ex_target[1:0]!=0: misalign_err=1 next cycle for one cycle, remain IDLE, no redirect, no flush.
REQ-022 First REDIRECT cycle: flush_if=flush_id=1 for exactly one cycle.
REQ-023 REDIRECT: redirect_valid=1, redirect_pc held constant until if_ready sampled high.
REQ-024 REDIRECT + if_ready: if SQUASH_CYCLES>0 load counter SQUASH_CYCLES-1, go SQUASH; else go IDLE.
REQ-025 SQUASH: squash_ex=1 each cycle; counter decrements; at counter 0 go IDLE next cycle.
REQ-026 Latency: trigger in cycle N -> redirect_valid and flushes high in cycle N+1.
REQ-027 ex_valid/ex_br_taken ignored in REDIRECT and SQUASH (wrong-path); no second capture.
REQ-028 stall_in in REDIRECT/SQUASH does not pause the FSM; stall_in only gates triggers in IDLE.
REQ-029 if_ready outside REDIRECT has no effect.
REQ-030 Back-to-back: trigger in the cycle the FSM returns to IDLE is accepted (IDLE evaluates triggers every cycle).

Reset
REQ-031 rst_n low at a clock edge: state IDLE, counter 0, redirect_pc 0, all single-bit outputs 0, counters 0.
REQ-032 Reset mid-REDIRECT or mid-SQUASH aborts immediately; pending redirect discarded, no flush pulse emitted after reset.

Configuration
REQ-033 Macro BR_STATS_EN defined: redirect_cnt increments on each REDIRECT->exit handshake, squash_cnt increments on each squash_ex cycle, both saturate at 16'hFFFF.
REQ-034 Macro BR_STATS_EN undefined: redirect_cnt and squash_cnt tied to 0, no counter registers synthesized; all other behaviour identical.

Verification
REQ-035 Reset, then BEQ trigger target 0x0000_0100, if_ready=1 next cycle -> cycle N+1 redirect_valid=1, redirect_pc=0x100, flush_if=flush_id=1; then squash_ex high 2 cycles, busy low after.
REQ-036 JAL trigger target 0x200, if_ready low 5 cycles -> redirect_valid held 5+ cycles, redirect_pc stable 0x200, flushes high only first cycle.
REQ-037 JALR trigger target 0x0000_0102 -> misalign_err one-cycle pulse, redirect_valid stays 0, busy stays 0.
REQ-038 Trigger with stall_in=1, or opcode 0110011 with ex_br_taken=1 -> no redirect; second taken branch during SQUASH -> ignored, redirect_cnt increments by 1 only (BR_STATS_EN).
REQ-039 rst_n low in the second REDIRECT cycle -> next cycle all outputs 0, state IDLE; a subsequent trigger redirects normally.
REQ-040 SQUASH_CYCLES=0 build: handshake -> IDLE next cycle, squash_ex never asserted; with BR_STATS_EN undefined, counters read 0 throughout.
